bure_ex_ctrl: RTL and testbench
===============================

// Module: bure_ex_ctrl
// PURPOSE
// - Sequencer for the execute stage. Accepts decoded ops from decode with a valid/ready handshake.
// - Resolves operand forwarding from MEM/WB and drives the single-cycle bure_alu.
// - Launches and waits on the multi-cycle muldiv unit.
// - Presents one result per op to MEM with a valid/ready handshake. Handles flush and muldiv timeout.
// PARAMETERS
// - DATA_WIDTH   32   operand/result width
// - MD_TIMEOUT   64   max cycles in MD_WAIT before error; >=2
// PORTS
// - Clock/reset:
//   - i_clk            in   1   clock; single clock domain
//   - i_rst            in   1   reset, synchronous, active-high
// - Decode side:
//   - i_decode_valid   in   1   decode offers op
//   - o_decode_ready   out  1   op accepted when valid&ready
//   - i_op_funct3      in   3   ALU/muldiv function
//   - i_op_funct7      in   7   ALU function modifier
//   - i_op_is_md       in   1   op goes to muldiv
//   - i_op_use_imm     in   1   rhs = i_imm instead of rs2
//   - i_imm            in   DW  sign-extended immediate
//   - i_rs1_addr       in   5   source register 1 index
//   - i_rs2_addr       in   5   source register 2 index
//   - i_rd_addr        in   5   destination register index
//   - i_rs1_data       in   DW  register-file read data 1
//   - i_rs2_data       in   DW  register-file read data 2
// - Forwarding:
//   - i_mem_fwd_vld    in   1   MEM stage holds a result for i_mem_fwd_rd
//   - i_mem_fwd_rd     in   5   MEM destination index
//   - i_mem_fwd_data   in   DW  MEM result
//   - i_wb_fwd_vld     in   1   WB stage holds a result for i_wb_fwd_rd
//   - i_wb_fwd_rd      in   5   WB destination index
//   - i_wb_fwd_data    in   DW  WB result
// - ALU:
//   - o_alu_funct3     out  3   to bure_alu
//   - o_alu_funct7     out  7   to bure_alu
//   - o_alu_lhs        out  DW  to bure_alu
//   - o_alu_rhs        out  DW  to bure_alu
//   - i_alu_data       in   DW  bure_alu result (combinational)
// - Muldiv:
//   - o_md_start       out  1   1-cycle launch pulse
//   - o_md_abort       out  1   1-cycle cancel pulse
//   - o_md_funct3      out  3   muldiv function
//   - o_md_lhs         out  DW  muldiv operand
//   - o_md_rhs         out  DW  muldiv operand
//   - i_md_done        in   1   muldiv result valid, 1-cycle
//   - i_md_data        in   DW  muldiv result
// - Control and MEM side:
//   - i_flush          in   1   kill in-flight op
//   - o_ex_valid       out  1   result offered to MEM
//   - i_ex_ready       in   1   MEM accepts
//   - o_ex_data        out  DW  result
//   - o_ex_rd          out  5   destination of result
//   - o_ex_err         out  1   result is a muldiv timeout; qualifies o_ex_valid
//   - o_busy           out  1   state != IDLE
// BEHAVIOUR
// - Reset (i_rst=1 at a clock edge):
//   - state=IDLE; operand, output and counter registers 0.
//   - All registered outputs 0. o_decode_ready=0 while i_rst is high.
// - FSM states: IDLE, EXEC, MD_WAIT, OUT.
// - Accept: when o_decode_ready & i_decode_valid.
//   - o_decode_ready = !i_flush & (IDLE | (OUT & i_ex_ready)).
//   - Operands latch on accept.
//   - Next state is EXEC (i_op_is_md=0) or MD_WAIT (i_op_is_md=1).
// - Forwarding, evaluated at accept, per source:
//   - MEM match beats WB match; WB match beats RF data.
//   - Index 0 never forwards; data is 0.
// - Operand rules:
//   - rhs = i_imm if i_op_use_imm.
//   - funct7 forced 0 if use_imm, except funct3=3'b101 (shift-right imm), which keeps funct7.
// - EXEC: 1 cycle. i_alu_data captured into o_ex_data -> OUT.
//   - Accept in cycle N gives o_ex_valid=1 in cycle N+2.
//   - ALU throughput is 1 op / 2 cycles.
// - MD_WAIT:
//   - o_md_start=1 in the first cycle only.
//   - Counter increments each cycle.
//   - On i_md_done: capture i_md_data -> OUT.
//   - If the counter reaches MD_TIMEOUT-1 without done: o_ex_data=0, o_ex_err=1, o_md_abort pulse -> OUT.
//   - Done and timeout in the same cycle: done wins.
// - OUT:
//   - o_ex_valid=1; o_ex_data/o_ex_rd/o_ex_err held stable until i_ex_ready.
//   - On handshake: new accept -> EXEC/MD_WAIT; otherwise -> IDLE.
// - Flush (any state): next state IDLE; o_ex_valid=0 next cycle; counter cleared.
//   - If in MD_WAIT: o_md_abort=1 for one cycle.
//   - Flush in the same cycle as i_md_done: result discarded.
// - ALU/muldiv operand outputs hold their value outside EXEC/MD_WAIT. The ALU and the muldiv unit never see a new op mid-operation.
// STRUCTURE
// - Package bure_ex_pkg:
//   - ex_state_e (IDLE, EXEC, MD_WAIT, OUT)
//   - fwd_sel_e (RF, MEM, WB, ZERO)
//   - funct3 constants (FUNCT3_SR=3'b101)
//   - REG_ADDR_W=5
// - Sub-module bure_ex_fwd: combinational per-operand forwarding mux (addr, rf data, MEM/WB taps -> data, fwd_sel_e). Instantiated twice.
// - bure_alu and the muldiv unit stay outside; this block only drives their ports.
// TESTING
// - Reset: hold i_rst 3 cycles with i_decode_valid=1 -> o_ex_valid=0, o_decode_ready=0, o_md_start=0; ready=1 the first cycle after release.
// - ALU add: rs1=5, rs2=7, funct3=0, funct7=0, rd=3 accepted at N -> o_alu_lhs=5, o_alu_rhs=7 at N+1; o_ex_valid=1, o_ex_data=12, o_ex_rd=3 at N+2.
// - Forwarding: rs1_addr=4, MEM rd=4 data=0xAA, WB rd=4 data=0xBB -> lhs=0xAA; rs2_addr=0, MEM rd=0 data=0xCC -> rhs=0.
// - Backpressure: i_ex_ready=0 for 5 cycles in OUT -> o_ex_data stable, o_decode_ready=0; ready=1 -> next op accepted in the same cycle.
// - Muldiv: i_op_is_md=1, i_md_done after 10 cycles with data=0x1234 -> one o_md_start pulse, o_ex_data=0x1234, o_ex_err=0.
//   - With MD_TIMEOUT=8 and no done -> o_md_abort pulse, o_ex_err=1, o_ex_data=0.
// - Flush: assert i_flush in MD_WAIT with i_md_done in the same cycle -> IDLE, o_md_abort=1, no o_ex_valid for that op.

Source files
------------

// File: rtl/bure_ex_pkg.sv
// Shared types and constants for the bure execute-stage controller.
package bure_ex_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_W   = 7;

    localparam logic [FUNCT3_W-1:0] FUNCT3_SR = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MD_WAIT,
        OUT
    } ex_state_e;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB,
        FWD_ZERO
    } fwd_sel_e;

    // Immediate forms carry no funct7, except shift-right which uses it for arith/logical.
    function automatic logic [FUNCT7_W-1:0] op_funct7(
        input logic                use_imm,
        input logic [FUNCT3_W-1:0] funct3,
        input logic [FUNCT7_W-1:0] funct7
    );
        if (use_imm && (funct3 != FUNCT3_SR)) begin
            return '0;
        end
        return funct7;
    endfunction

endpackage

// File: rtl/bure_ex_fwd.sv
// Per-operand forwarding mux: MEM over WB over register file; index 0 reads zero.
module bure_ex_fwd
    import bure_ex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  mem_vld_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  wb_vld_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output fwd_sel_e              sel_o
);

    always_comb begin
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        if (addr_i == '0) begin
            sel_o  = FWD_ZERO;
            data_o = '0;
        end else if (mem_vld_i && (mem_rd_i == addr_i)) begin
            sel_o  = FWD_MEM;
            data_o = mem_data_i;
        end else if (wb_vld_i && (wb_rd_i == addr_i)) begin
            sel_o  = FWD_WB;
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/bure_ex_ctrl.sv
// Execute-stage sequencer: accepts decoded ops, drives the ALU or muldiv unit,
// and hands one result per op to MEM with a valid/ready handshake.
module bure_ex_ctrl
    import bure_ex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_decode_valid,
    output logic                  o_decode_ready,
    input  logic [FUNCT3_W-1:0]   i_op_funct3,
    input  logic [FUNCT7_W-1:0]   i_op_funct7,
    input  logic                  i_op_is_md,
    input  logic                  i_op_use_imm,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic                  i_mem_fwd_vld,
    input  logic [REG_ADDR_W-1:0] i_mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_fwd_data,
    input  logic                  i_wb_fwd_vld,
    input  logic [REG_ADDR_W-1:0] i_wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_fwd_data,
    output logic [FUNCT3_W-1:0]   o_alu_funct3,
    output logic [FUNCT7_W-1:0]   o_alu_funct7,
    output logic [DATA_WIDTH-1:0] o_alu_lhs,
    output logic [DATA_WIDTH-1:0] o_alu_rhs,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    output logic                  o_md_start,
    output logic                  o_md_abort,
    output logic [FUNCT3_W-1:0]   o_md_funct3,
    output logic [DATA_WIDTH-1:0] o_md_lhs,
    output logic [DATA_WIDTH-1:0] o_md_rhs,
    input  logic                  i_md_done,
    input  logic [DATA_WIDTH-1:0] i_md_data,
    input  logic                  i_flush,
    output logic                  o_ex_valid,
    input  logic                  i_ex_ready,
    output logic [DATA_WIDTH-1:0] o_ex_data,
    output logic [REG_ADDR_W-1:0] o_ex_rd,
    output logic                  o_ex_err,
    output logic                  o_busy
);

    localparam int unsigned     CNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    ex_state_e               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [REG_ADDR_W-1:0]   op_rd_q;
    logic [FUNCT3_W-1:0]     alu_funct3_q;
    logic [FUNCT7_W-1:0]     alu_funct7_q;
    logic [DATA_WIDTH-1:0]   alu_lhs_q;
    logic [DATA_WIDTH-1:0]   alu_rhs_q;
    logic                    md_start_q;
    logic                    md_abort_q;
    logic [FUNCT3_W-1:0]     md_funct3_q;
    logic [DATA_WIDTH-1:0]   md_lhs_q;
    logic [DATA_WIDTH-1:0]   md_rhs_q;
    logic                    ex_valid_q;
    logic [DATA_WIDTH-1:0]   ex_data_q;
    logic [REG_ADDR_W-1:0]   ex_rd_q;
    logic                    ex_err_q;

    logic [DATA_WIDTH-1:0]   rs1_fwd;
    logic [DATA_WIDTH-1:0]   rs2_fwd;
    fwd_sel_e                rs1_sel;
    fwd_sel_e                rs2_sel;
    logic [DATA_WIDTH-1:0]   rhs_c;
    logic                    accept_c;

    bure_ex_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
        .addr_i     (i_rs1_addr),
        .rf_data_i  (i_rs1_data),
        .mem_vld_i  (i_mem_fwd_vld),
        .mem_rd_i   (i_mem_fwd_rd),
        .mem_data_i (i_mem_fwd_data),
        .wb_vld_i   (i_wb_fwd_vld),
        .wb_rd_i    (i_wb_fwd_rd),
        .wb_data_i  (i_wb_fwd_data),
        .data_o     (rs1_fwd),
        .sel_o      (rs1_sel)
    );

    bure_ex_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
        .addr_i     (i_rs2_addr),
        .rf_data_i  (i_rs2_data),
        .mem_vld_i  (i_mem_fwd_vld),
        .mem_rd_i   (i_mem_fwd_rd),
        .mem_data_i (i_mem_fwd_data),
        .wb_vld_i   (i_wb_fwd_vld),
        .wb_rd_i    (i_wb_fwd_rd),
        .wb_data_i  (i_wb_fwd_data),
        .data_o     (rs2_fwd),
        .sel_o      (rs2_sel)
    );

    // A new op enters only when the stage is empty or its result leaves this cycle.
    assign o_decode_ready = !i_rst && !i_flush &&
                            ((state_q == IDLE) || ((state_q == OUT) && i_ex_ready));
    assign accept_c       = o_decode_ready && i_decode_valid;
    assign rhs_c          = i_op_use_imm ? i_imm : rs2_fwd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_rd_q      <= '0;
            alu_funct3_q <= '0;
            alu_funct7_q <= '0;
            alu_lhs_q    <= '0;
            alu_rhs_q    <= '0;
            md_start_q   <= 1'b0;
            md_abort_q   <= 1'b0;
            md_funct3_q  <= '0;
            md_lhs_q     <= '0;
            md_rhs_q     <= '0;
            ex_valid_q   <= 1'b0;
            ex_data_q    <= '0;
            ex_rd_q      <= '0;
            ex_err_q     <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            md_abort_q <= 1'b0;
            if (i_flush) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                ex_valid_q <= 1'b0;
                ex_err_q   <= 1'b0;
                md_abort_q <= (state_q == MD_WAIT);
            end else if (accept_c) begin
                op_rd_q    <= i_rd_addr;
                cnt_q      <= '0;
                ex_valid_q <= 1'b0;
                ex_err_q   <= 1'b0;
                if (i_op_is_md) begin
                    md_funct3_q <= i_op_funct3;
                    md_lhs_q    <= rs1_fwd;
                    md_rhs_q    <= rhs_c;
                    md_start_q  <= 1'b1;
                    state_q     <= MD_WAIT;
                end else begin
                    alu_funct3_q <= i_op_funct3;
                    alu_funct7_q <= op_funct7(i_op_use_imm, i_op_funct3, i_op_funct7);
                    alu_lhs_q    <= rs1_fwd;
                    alu_rhs_q    <= rhs_c;
                    state_q      <= EXEC;
                end
            end else begin
                case (state_q)
                    EXEC: begin
                        ex_data_q  <= i_alu_data;
                        ex_rd_q    <= op_rd_q;
                        ex_err_q   <= 1'b0;
                        ex_valid_q <= 1'b1;
                        state_q    <= OUT;
                    end
                    MD_WAIT: begin
                        // Done takes priority over a timeout landing in the same cycle.
                        if (i_md_done) begin
                            ex_data_q  <= i_md_data;
                            ex_rd_q    <= op_rd_q;
                            ex_err_q   <= 1'b0;
                            ex_valid_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= OUT;
                        end else if (cnt_q == CNT_LAST) begin
                            ex_data_q  <= '0;
                            ex_rd_q    <= op_rd_q;
                            ex_err_q   <= 1'b1;
                            ex_valid_q <= 1'b1;
                            md_abort_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= OUT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    OUT: begin
                        if (i_ex_ready) begin
                            ex_valid_q <= 1'b0;
                            ex_err_q   <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Register index 0 must always read as zero, whatever the taps hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept_c) begin
            assert ((rs1_sel != FWD_ZERO) || (rs1_fwd == '0));
            assert ((rs2_sel != FWD_ZERO) || (rs2_fwd == '0));
        end
    end

    assign o_alu_funct3 = alu_funct3_q;
    assign o_alu_funct7 = alu_funct7_q;
    assign o_alu_lhs    = alu_lhs_q;
    assign o_alu_rhs    = alu_rhs_q;
    assign o_md_start   = md_start_q;
    assign o_md_abort   = md_abort_q;
    assign o_md_funct3  = md_funct3_q;
    assign o_md_lhs     = md_lhs_q;
    assign o_md_rhs     = md_rhs_q;
    assign o_ex_valid   = ex_valid_q;
    assign o_ex_data    = ex_data_q;
    assign o_ex_rd      = ex_rd_q;
    assign o_ex_err     = ex_err_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bure_ex_ctrl.sv
// Directed bench for bure_ex_ctrl: ALU vector table plus backpressure, muldiv, timeout and flush sequences.
module tb_bure_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_md;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [31:0] rs1_d, rs2_d;
    logic        mem_vld, wb_vld;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_d, wb_d;
    logic        md_done;
    logic [31:0] md_data;
    logic        flush;
    logic        ex_ready;

    // Outputs of the main instance (MD_TIMEOUT=64)
    logic        dec_ready;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic [31:0] alu_lhs, alu_rhs, alu_data;
    logic        md_start, md_abort;
    logic [2:0]  md_f3;
    logic [31:0] md_lhs, md_rhs;
    logic        ex_valid, ex_err, busy;
    logic [31:0] ex_data;
    logic [4:0]  ex_rd;

    // Outputs of the short-timeout instance (MD_TIMEOUT=8)
    logic        t_dec_ready;
    logic [2:0]  t_alu_f3;
    logic [6:0]  t_alu_f7;
    logic [31:0] t_alu_lhs, t_alu_rhs, t_alu_data;
    logic        t_md_start, t_md_abort;
    logic [2:0]  t_md_f3;
    logic [31:0] t_md_lhs, t_md_rhs;
    logic        t_ex_valid, t_ex_err, t_busy;
    logic [31:0] t_ex_data;
    logic [4:0]  t_ex_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference ALU: funct3 0 is add/sub (funct7[5]), everything else xor.
    assign alu_data   = (alu_f3 == 3'd0) ? (alu_f7[5] ? alu_lhs - alu_rhs : alu_lhs + alu_rhs)
                                         : (alu_lhs ^ alu_rhs);
    assign t_alu_data = (t_alu_f3 == 3'd0) ? (t_alu_f7[5] ? t_alu_lhs - t_alu_rhs : t_alu_lhs + t_alu_rhs)
                                           : (t_alu_lhs ^ t_alu_rhs);

    bure_ex_ctrl #(.DATA_WIDTH(32), .MD_TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_decode_valid(dec_valid), .o_decode_ready(dec_ready),
        .i_op_funct3(f3), .i_op_funct7(f7), .i_op_is_md(is_md), .i_op_use_imm(use_imm),
        .i_imm(imm), .i_rs1_addr(rs1_a), .i_rs2_addr(rs2_a), .i_rd_addr(rd_a),
        .i_rs1_data(rs1_d), .i_rs2_data(rs2_d),
        .i_mem_fwd_vld(mem_vld), .i_mem_fwd_rd(mem_rd), .i_mem_fwd_data(mem_d),
        .i_wb_fwd_vld(wb_vld), .i_wb_fwd_rd(wb_rd), .i_wb_fwd_data(wb_d),
        .o_alu_funct3(alu_f3), .o_alu_funct7(alu_f7), .o_alu_lhs(alu_lhs), .o_alu_rhs(alu_rhs),
        .i_alu_data(alu_data),
        .o_md_start(md_start), .o_md_abort(md_abort), .o_md_funct3(md_f3),
        .o_md_lhs(md_lhs), .o_md_rhs(md_rhs), .i_md_done(md_done), .i_md_data(md_data),
        .i_flush(flush), .o_ex_valid(ex_valid), .i_ex_ready(ex_ready), .o_ex_data(ex_data),
        .o_ex_rd(ex_rd), .o_ex_err(ex_err), .o_busy(busy)
    );

    bure_ex_ctrl #(.DATA_WIDTH(32), .MD_TIMEOUT(8)) dut_to (
        .i_clk(clk), .i_rst(rst), .i_decode_valid(dec_valid), .o_decode_ready(t_dec_ready),
        .i_op_funct3(f3), .i_op_funct7(f7), .i_op_is_md(is_md), .i_op_use_imm(use_imm),
        .i_imm(imm), .i_rs1_addr(rs1_a), .i_rs2_addr(rs2_a), .i_rd_addr(rd_a),
        .i_rs1_data(rs1_d), .i_rs2_data(rs2_d),
        .i_mem_fwd_vld(mem_vld), .i_mem_fwd_rd(mem_rd), .i_mem_fwd_data(mem_d),
        .i_wb_fwd_vld(wb_vld), .i_wb_fwd_rd(wb_rd), .i_wb_fwd_data(wb_d),
        .o_alu_funct3(t_alu_f3), .o_alu_funct7(t_alu_f7), .o_alu_lhs(t_alu_lhs), .o_alu_rhs(t_alu_rhs),
        .i_alu_data(t_alu_data),
        .o_md_start(t_md_start), .o_md_abort(t_md_abort), .o_md_funct3(t_md_f3),
        .o_md_lhs(t_md_lhs), .o_md_rhs(t_md_rhs), .i_md_done(md_done), .i_md_data(md_data),
        .i_flush(flush), .o_ex_valid(t_ex_valid), .i_ex_ready(ex_ready), .o_ex_data(t_ex_data),
        .o_ex_rd(t_ex_rd), .o_ex_err(t_ex_err), .o_busy(t_busy)
    );

    typedef struct {
        logic [4:0]  rs1_a, rs2_a, rd;
        logic [31:0] rs1_d, rs2_d;
        logic        use_imm;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] e_lhs, e_rhs;
        logic [6:0]  e_f7;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v, input logic md);
        rs1_a = v.rs1_a; rs2_a = v.rs2_a; rd_a = v.rd;
        rs1_d = v.rs1_d; rs2_d = v.rs2_d;
        use_imm = v.use_imm; imm = v.imm; f3 = v.f3; f7 = v.f7;
        mem_vld = v.mv; mem_rd = v.mrd; mem_d = v.md;
        wb_vld = v.wv; wb_rd = v.wrd; wb_d = v.wd;
        is_md = md;
        dec_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dec_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   starts;
        int   found;

        // rs1_a rs2_a rd  rs1_d rs2_d  imm?  imm  f3 f7  mem{v,rd,d}  wb{v,rd,d}  exp lhs rhs f7 data
        vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 32'd0, 3'd0, 7'd0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 7'd0, 32'd12};
        vecs[1] = '{5'd4, 5'd5, 5'd8, 32'h11, 32'h3, 1'b0, 32'd0, 3'd0, 7'd0,
                    1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, 32'hAA, 32'h3, 7'd0, 32'hAD};
        vecs[2] = '{5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 1'b0, 32'd0, 3'd0, 7'd0,
                    1'b1, 5'd0, 32'hCC, 1'b1, 5'd0, 32'hDD, 32'h0, 32'h0, 7'd0, 32'h0};
        vecs[3] = '{5'd6, 5'd7, 5'd10, 32'h10, 32'h1, 1'b0, 32'd0, 3'd0, 7'd0,
                    1'b0, 5'd6, 32'h99, 1'b1, 5'd6, 32'h20, 32'h20, 32'h1, 7'd0, 32'h21};
        vecs[4] = '{5'd1, 5'd9, 5'd11, 32'h100, 32'h2, 1'b0, 32'd0, 3'd0, 7'd0,
                    1'b1, 5'd9, 32'h50, 1'b1, 5'd9, 32'h60, 32'h100, 32'h50, 7'd0, 32'h150};
        vecs[5] = '{5'd2, 5'd3, 5'd12, 32'd10, 32'h77, 1'b1, 32'hFFFF_FFFF, 3'd0, 7'h20,
                    1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'd0, 32'd10, 32'hFFFF_FFFF, 7'd0, 32'd9};
        vecs[6] = '{5'd2, 5'd3, 5'd13, 32'hF0, 32'h77, 1'b1, 32'h3, 3'd5, 7'h20,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF0, 32'h3, 7'h20, 32'hF3};
        vecs[7] = '{5'd2, 5'd3, 5'd14, 32'd20, 32'd7, 1'b0, 32'd0, 3'd0, 7'h20,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd20, 32'd7, 7'h20, 32'd13};
        vecs[8] = '{5'd2, 5'd3, 5'd15, 32'h0F, 32'h77, 1'b1, 32'hF0, 3'd1, 7'h20,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0F, 32'hF0, 7'd0, 32'hFF};

        rst = 1'b1; dec_valid = 1'b1; f3 = '0; f7 = '0; is_md = 1'b0; use_imm = 1'b0;
        imm = '0; rs1_a = '0; rs2_a = '0; rd_a = '0; rs1_d = '0; rs2_d = '0;
        mem_vld = 1'b0; mem_rd = '0; mem_d = '0; wb_vld = 1'b0; wb_rd = '0; wb_d = '0;
        md_done = 1'b0; md_data = '0; flush = 1'b0; ex_ready = 1'b1;

        // Reset held for 3 cycles with decode offering an op
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_ex_valid", i), 32'(ex_valid), 32'd0);
            chk($sformatf("rst%0d_dec_ready", i), 32'(dec_ready), 32'd0);
            chk($sformatf("rst%0d_md_start", i), 32'(md_start), 32'd0);
        end
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        dec_valid = 1'b0;
        #1 chk("rst_release_ready", 32'(dec_ready), 32'd1);

        // ALU vector table
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            drive_op(vecs[n], 1'b0);
            #1 chk($sformatf("v%0d_accept_ready", n), 32'(dec_ready), 32'd1);
            @(negedge clk);
            dec_valid = 1'b0;
            chk($sformatf("v%0d_lhs", n), alu_lhs, vecs[n].e_lhs);
            chk($sformatf("v%0d_rhs", n), alu_rhs, vecs[n].e_rhs);
            chk($sformatf("v%0d_f7", n), 32'(alu_f7), 32'(vecs[n].e_f7));
            chk($sformatf("v%0d_f3", n), 32'(alu_f3), 32'(vecs[n].f3));
            chk($sformatf("v%0d_valid_n1", n), 32'(ex_valid), 32'd0);
            chk($sformatf("v%0d_ready_n1", n), 32'(dec_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid_n2", n), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_data", n), ex_data, vecs[n].e_data);
            chk($sformatf("v%0d_rd", n), 32'(ex_rd), 32'(vecs[n].rd));
            chk($sformatf("v%0d_err", n), 32'(ex_err), 32'd0);
        end

        // Backpressure: result held while MEM stalls, next op accepted on the release cycle
        @(negedge clk);
        ex_ready = 1'b0;
        v = vecs[0];
        v.rs1_d = 32'd1; v.rs2_d = 32'd2; v.rd = 5'd5;
        drive_op(v, 1'b0);
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid", 32'(ex_valid), 32'd1);
        chk("bp_data", ex_data, 32'd3);
        v.rs1_d = 32'h40; v.rd = 5'd6;
        drive_op(v, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_data", i), ex_data, 32'd3);
            chk($sformatf("bp_hold%0d_rd", i), 32'(ex_rd), 32'd5);
            chk($sformatf("bp_hold%0d_valid", i), 32'(ex_valid), 32'd1);
            #1 chk($sformatf("bp_hold%0d_ready", i), 32'(dec_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(dec_ready), 32'd1);
        @(negedge clk);
        dec_valid = 1'b0;
        chk("bp_next_lhs", alu_lhs, 32'h40);
        chk("bp_next_valid_n1", 32'(ex_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(ex_valid), 32'd1);
        chk("bp_next_data", ex_data, 32'h42);
        chk("bp_next_rd", 32'(ex_rd), 32'd6);

        // Muldiv with done after 10 cycles
        @(negedge clk);
        v = vecs[0];
        v.rs1_d = 32'd6; v.rs2_d = 32'd7; v.rd = 5'd7; v.f3 = 3'd4;
        drive_op(v, 1'b1);
        starts = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            dec_valid = 1'b0;
            is_md = 1'b0;
            starts += int'(md_start);
            if (k == 1) begin
                chk("md_start_first", 32'(md_start), 32'd1);
                chk("md_lhs", md_lhs, 32'd6);
                chk("md_rhs", md_rhs, 32'd7);
                chk("md_f3", 32'(md_f3), 32'd4);
            end
            if (k == 10) begin
                md_done = 1'b1;
                md_data = 32'h1234;
            end
        end
        chk("md_busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
        md_done = 1'b0;
        chk("md_start_count", 32'(starts), 32'd1);
        chk("md_valid", 32'(ex_valid), 32'd1);
        chk("md_data", ex_data, 32'h1234);
        chk("md_err", 32'(ex_err), 32'd0);
        chk("md_rd", 32'(ex_rd), 32'd7);
        chk("md_abort", 32'(md_abort), 32'd0);

        // Timeout on the MD_TIMEOUT=8 instance; first leave non-zero data in its output
        do_reset();
        @(negedge clk);
        v = vecs[0];
        v.rs1_d = 32'h5; v.rs2_d = 32'h6; v.rd = 5'd2;
        drive_op(v, 1'b0);
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        chk("to_alu_data", t_ex_data, 32'hB);
        @(negedge clk);
        v.rd = 5'd9;
        drive_op(v, 1'b1);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            dec_valid = 1'b0;
            is_md = 1'b0;
            if (t_ex_valid && found == 0) begin
                found = k;
                chk("to_err", 32'(t_ex_err), 32'd1);
                chk("to_data", t_ex_data, 32'd0);
                chk("to_rd", 32'(t_ex_rd), 32'd9);
                chk("to_abort", 32'(t_md_abort), 32'd1);
                break;
            end
        end
        chk("to_cycle", 32'(found), 32'd9);
        @(negedge clk);
        chk("to_abort_clear", 32'(t_md_abort), 32'd0);

        // Flush in MD_WAIT coinciding with done: result dropped, abort pulsed
        do_reset();
        @(negedge clk);
        v = vecs[0];
        v.rd = 5'd4;
        drive_op(v, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dec_valid = 1'b0;
            is_md = 1'b0;
        end
        flush = 1'b1;
        md_done = 1'b1;
        md_data = 32'h77;
        #1 chk("fl_ready_during_flush", 32'(dec_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        md_done = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_abort", 32'(md_abort), 32'd1);
        chk("fl_valid", 32'(ex_valid), 32'd0);
        #1 chk("fl_ready_after", 32'(dec_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("fl_valid_after%0d", k), 32'(ex_valid), 32'd0);
            chk($sformatf("fl_abort_after%0d", k), 32'(md_abort), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
